regwrite_arbiter: RTL and testbench

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

---
 rtl/regwrite_arbiter_pkg.sv | 23 ++
 rtl/regwrite_fifo.sv | 80 ++++++++
 rtl/regwrite_arbiter.sv | 134 +++++++++++++
 tb/tb_regwrite_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regwrite_arbiter_pkg.sv
// Shared CPU constants and types for the register write-back path.
// This package supplies the default widths, register-number names and the write-source encoding.
package regwrite_arbiter_pkg;

  localparam int CPU_DATA_W  = 32;
  localparam int CPU_REG_N_W = 4;

  localparam logic [CPU_REG_N_W-1:0] REG_ZERO = 4'd0;
  localparam logic [CPU_REG_N_W-1:0] REG_SP   = 4'd14;
  localparam logic [CPU_REG_N_W-1:0] REG_LR   = 4'd15;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LQ   = 2'd2
  } wr_src_e;

  // Occupancy counter width for a queue of the given depth.
  function automatic int lq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/regwrite_fifo.sv
// Load-return queue: a small in-order FIFO with power-of-two depth.
// A pop and a push may happen together, including when the queue is full.
module regwrite_fifo
  import regwrite_arbiter_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = lq_cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (cnt_q == CNT_MAX);
  assign empty_o   = (cnt_q == {CNT_W{1'b0}});
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && (!full_o || pop_i);
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer and occupancy next state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage is not reset; the occupancy counter decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/regwrite_arbiter.sv
// Merges ALU write-back and queued load returns onto one register-file write port.
// It also keeps a pending-write scoreboard per register.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int REG_N_W  = CPU_REG_N_W,
  parameter int LQ_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid_i,
  input  logic [REG_N_W-1:0]      alu_num_i,
  input  logic [DATA_W-1:0]       alu_value_i,
  output logic                    alu_ready_o,
  input  logic                    ld_valid_i,
  input  logic [REG_N_W-1:0]      ld_num_i,
  input  logic [DATA_W-1:0]       ld_value_i,
  output logic                    ld_ready_o,
  input  logic                    mark_en_i,
  input  logic [REG_N_W-1:0]      mark_num_i,
  output logic                    reg_write_en_o,
  output logic [REG_N_W-1:0]      reg_num_o,
  output logic [DATA_W-1:0]       reg_value_o,
  output logic [2**REG_N_W-1:0]   busy_o
);

  localparam int ENTRY_W = DATA_W + REG_N_W;
  localparam int REG_CNT = 2**REG_N_W;

  logic [ENTRY_W-1:0] lq_rdata_s;
  logic               lq_full_s;
  logic               lq_empty_s;
  logic               lq_push_s;
  logic               lq_pop_s;
  wr_src_e            src_s;

  logic               reg_write_en_q, reg_write_en_d;
  logic [REG_N_W-1:0] reg_num_q, reg_num_d;
  logic [DATA_W-1:0]  reg_value_q, reg_value_d;
  logic [REG_CNT-1:0] busy_q, busy_d;

  // Both ready signals come from queue occupancy alone, so neither depends on a valid input.
  assign alu_ready_o = !lq_full_s;
  assign ld_ready_o  = !lq_full_s;
  assign lq_push_s   = ld_valid_i && ld_ready_o;
  assign lq_pop_s    = (src_s == SRC_LQ);

  regwrite_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (lq_push_s),
    .wdata_i ({ld_num_i, ld_value_i}),
    .pop_i   (lq_pop_s),
    .rdata_o (lq_rdata_s),
    .full_o  (lq_full_s),
    .empty_o (lq_empty_s)
  );

  // Winner selection: ALU by default, queue head when the ALU is idle or the queue is full.
  always_comb begin
    src_s = SRC_NONE;
    if (alu_valid_i && alu_ready_o) begin
      src_s = SRC_ALU;
    end else if (!lq_empty_s) begin
      src_s = SRC_LQ;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Write-port next state; number and value hold when there is no winner.
  always_comb begin
    reg_write_en_d = 1'b0;
    reg_num_d      = reg_num_q;
    reg_value_d    = reg_value_q;
    case (src_s)
      SRC_ALU: begin
        reg_write_en_d = 1'b1;
        reg_num_d      = alu_num_i;
        reg_value_d    = alu_value_i;
      end
      SRC_LQ: begin
        reg_write_en_d = 1'b1;
        reg_num_d      = lq_rdata_s[DATA_W +: REG_N_W];
        reg_value_d    = lq_rdata_s[DATA_W-1:0];
      end
      default: begin
        reg_write_en_d = 1'b0;
        reg_num_d      = reg_num_q;
        reg_value_d    = reg_value_q;
      end
    endcase
  end

  // Scoreboard: a presented write clears its register, and a mark applied afterwards wins.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_en_q) begin
      busy_d[reg_num_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mark_en_i) begin
      busy_d[mark_num_i] = 1'b1;
    end else begin
      busy_d[mark_num_i] = busy_d[mark_num_i];
    end
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_en_q <= 1'b0;
      reg_num_q      <= {REG_N_W{1'b0}};
      reg_value_q    <= {DATA_W{1'b0}};
      busy_q         <= {REG_CNT{1'b0}};
    end else begin
      reg_write_en_q <= reg_write_en_d;
      reg_num_q      <= reg_num_d;
      reg_value_q    <= reg_value_d;
      busy_q         <= busy_d;
    end
  end

  assign reg_write_en_o = reg_write_en_q;
  assign reg_num_o      = reg_num_q;
  assign reg_value_o    = reg_value_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: directed scenarios, then random traffic against a model.
module tb_regwrite_arbiter;

  localparam int DW    = 32;
  localparam int NW    = 4;
  localparam int DEPTH = 2;

  typedef struct {
    logic [NW-1:0] num;
    logic [DW-1:0] val;
    int            cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, ld_valid, mark_en;
  logic [NW-1:0] alu_num, ld_num, mark_num;
  logic [DW-1:0] alu_value, ld_value;
  logic          alu_ready, ld_ready;
  logic          reg_write_en;
  logic [NW-1:0] reg_num;
  logic [DW-1:0] reg_value;
  logic [15:0]   busy;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc   = 0;
  wr_t exp_q[$];
  wr_t m_lq[$];
  logic [15:0]   m_busy   = 16'h0000;
  logic          m_wr_en  = 1'b0;
  logic [NW-1:0] m_wr_num = 4'd0;

  regwrite_arbiter #(.DATA_W(DW), .REG_N_W(NW), .LQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid_i    (alu_valid),
    .alu_num_i      (alu_num),
    .alu_value_i    (alu_value),
    .alu_ready_o    (alu_ready),
    .ld_valid_i     (ld_valid),
    .ld_num_i       (ld_num),
    .ld_value_i     (ld_value),
    .ld_ready_o     (ld_ready),
    .mark_en_i      (mark_en),
    .mark_num_i     (mark_num),
    .reg_write_en_o (reg_write_en),
    .reg_num_o      (reg_num),
    .reg_value_o    (reg_value),
    .busy_o         (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected write whenever the DUT presents one; flags missed writes.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (reg_write_en === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got r%0d=0x%0h, required no write (cycle %0d)",
                   reg_num, reg_value, cyc);
        end else begin
          e = exp_q.pop_front();
          if (reg_num !== e.num || reg_value !== e.val || cyc != e.cyc) begin
            n_err++;
            $display("FAIL write: got r%0d=0x%0h at cycle %0d, required r%0d=0x%0h at cycle %0d",
                     reg_num, reg_value, cyc, e.num, e.val, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missed_write: got no write, required r%0d=0x%0h at cycle %0d",
                 e.num, e.val, e.cyc);
      end
    end
  end

  // One clock: check ready/busy against the model, advance the model, then take the edge.
  task automatic step();
    wr_t  w;
    logic full;
    logic [15:0] nb;
    full = (m_lq.size() == DEPTH);
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, !full});
    chk("ld_ready",  {63'd0, ld_ready},  {63'd0, !full});
    chk("busy",      {48'd0, busy},      {48'd0, m_busy});
    if (mark_en && m_busy[mark_num] && !(m_wr_en && m_wr_num == mark_num))
      $display("protocol error: mark on already-busy r%0d (cycle %0d)", mark_num, cyc);
    nb = m_busy;
    if (m_wr_en) nb[m_wr_num] = 1'b0;
    if (mark_en) nb[mark_num] = 1'b1;
    m_busy  = nb;
    m_wr_en = 1'b0;
    if (alu_valid && !full) begin
      w.num = alu_num; w.val = alu_value; w.cyc = cyc + 1;
      exp_q.push_back(w);
      m_wr_en = 1'b1; m_wr_num = alu_num;
    end else if (m_lq.size() > 0) begin
      w = m_lq.pop_front();
      w.cyc = cyc + 1;
      exp_q.push_back(w);
      m_wr_en = 1'b1; m_wr_num = w.num;
    end
    if (ld_valid && !full) begin
      w.num = ld_num; w.val = ld_value; w.cyc = 0;
      m_lq.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; mark_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},     {63'd0, reg_write_en}, 64'd0);
    chk({tag, "_num"},       {60'd0, reg_num},      64'd0);
    chk({tag, "_value"},     {32'd0, reg_value},    64'd0);
    chk({tag, "_busy"},      {48'd0, busy},         64'd0);
    chk({tag, "_ld_ready"},  {63'd0, ld_ready},     64'd1);
    chk({tag, "_alu_ready"}, {63'd0, alu_ready},    64'd1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lq.delete();
    m_busy = 16'h0000;
    m_wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    alu_num = 4'd0; alu_value = 32'd0; ld_num = 4'd0; ld_value = 32'd0; mark_num = 4'd0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: ALU only.
    alu_valid = 1'b1; alu_num = 4'd3; alu_value = 32'h1234;
    step();
    chk("s1_en",    {63'd0, reg_write_en}, 64'd1);
    chk("s1_num",   {60'd0, reg_num},      64'd3);
    chk("s1_value", {32'd0, reg_value},    64'h1234);
    idle_inputs();
    step();
    chk("s1_pulse", {63'd0, reg_write_en}, 64'd0);
    chk("s1_hold",  {60'd0, reg_num},      64'd3);

    // Scenario 2: ALU and load collide with the queue empty.
    alu_valid = 1'b1; alu_num = 4'd5; alu_value = 32'hA;
    ld_valid  = 1'b1; ld_num  = 4'd6; ld_value  = 32'hB;
    step();
    chk("s2_first", {60'd0, reg_num}, 64'd5);
    chk("s2_alu_ready", {63'd0, alu_ready}, 64'd1);
    idle_inputs();
    step();
    chk("s2_second",   {60'd0, reg_num},   64'd6);
    chk("s2_second_v", {32'd0, reg_value}, 64'hB);
    step();

    // Scenario 3: fill the queue while the ALU stays valid.
    alu_valid = 1'b1; alu_num = 4'd10; alu_value = 32'hC0;
    ld_valid  = 1'b1; ld_num  = 4'd1;  ld_value  = 32'h11;
    step();
    ld_num = 4'd2; ld_value = 32'h22;
    step();
    ld_valid = 1'b0;
    chk("s3_alu_stall", {63'd0, alu_ready}, 64'd0);
    chk("s3_ld_full",   {63'd0, ld_ready},  64'd0);
    step();
    chk("s3_r1_num",    {60'd0, reg_num},   64'd1);
    chk("s3_r1_val",    {32'd0, reg_value}, 64'h11);
    chk("s3_ld_back",   {63'd0, ld_ready},  64'd1);
    chk("s3_alu_back",  {63'd0, alu_ready}, 64'd1);
    alu_valid = 1'b0;
    step();
    chk("s3_r2_num",    {60'd0, reg_num},   64'd2);
    step();

    // Scenario 4: scoreboard set, clear and coincident set.
    mark_en = 1'b1; mark_num = 4'd7;
    step();
    mark_en = 1'b0;
    chk("s4_mark", {63'd0, busy[7]}, 64'd1);
    ld_valid = 1'b1; ld_num = 4'd7; ld_value = 32'h77;
    step();
    ld_valid = 1'b0;
    step();
    chk("s4_wr_r7",     {60'd0, reg_num}, 64'd7);
    chk("s4_busy_held", {63'd0, busy[7]}, 64'd1);
    step();
    chk("s4_cleared",   {63'd0, busy[7]}, 64'd0);
    mark_en = 1'b1; mark_num = 4'd7;
    step();
    mark_en = 1'b0;
    ld_valid = 1'b1; ld_num = 4'd7; ld_value = 32'h78;
    step();
    ld_valid = 1'b0;
    step();
    mark_en = 1'b1; mark_num = 4'd7;
    step();
    mark_en = 1'b0;
    chk("s4_set_wins", {63'd0, busy[7]}, 64'd1);
    step();

    // Scenario 5: reset with two queued loads.
    alu_valid = 1'b1; alu_num = 4'd9; alu_value = 32'h99;
    ld_valid = 1'b1; ld_num = 4'd1; ld_value = 32'h101;
    step();
    ld_num = 4'd2; ld_value = 32'h202;
    step();
    chk("s5_full", {63'd0, ld_ready}, 64'd0);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("s5");
    @(posedge clk);
    #2;
    check_reset_outputs("s5_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_no_write", {63'd0, reg_write_en}, 64'd0);
    repeat (3) step();

    // Scenario 6: random ALU/load/mark traffic.
    for (int i = 0; i < 10000; i++) begin
      logic [NW-1:0] r;
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_num   = NW'($urandom_range(0, 15));
      alu_value = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 1);
      ld_num    = NW'($urandom_range(0, 15));
      ld_value  = $urandom;
      r = NW'($urandom_range(0, 15));
      mark_num  = r;
      mark_en   = ($urandom_range(0, 3) == 0) && !m_busy[r];
      step();
    end
    idle_inputs();
    repeat (DEPTH + 3) step();
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
